// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, code table lookup and unit timing.
// MORSE_EOM_EN adds the EOT (0x04) -> AR prosign mapping and a 7-unit end-of-message gap.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        LETTER_GAP,
        WORD_GAP,
        DROP
    } state_e;

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } morse_code_t;

    typedef struct packed {
        logic        valid;
        logic        eom;
        morse_code_t code;
    } morse_lookup_t;

    localparam int DOT_UNITS        = 1;
    localparam int DASH_UNITS       = 3;
    localparam int ELEM_GAP_UNITS   = 1;
    localparam int LETTER_GAP_UNITS = 3;
    localparam int WORD_EXTRA_UNITS = 4;

`ifdef MORSE_EOM_EN
    localparam int EOM_WORD_UNITS = 7;
    localparam int UNIT_W         = 3;
`else
    localparam int UNIT_W         = 2;
`endif

    // A space is reported valid with len 0; pat bits are 1 = dash, sent from pat[len-1] down.
    function automatic morse_lookup_t ascii_to_morse(input logic [7:0] ch);
        morse_lookup_t r;
        logic [7:0]    up;
        logic [3:0]    digit;
        r     = '0;
        up    = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
        digit = up[3:0];
        if (up >= 8'h30 && up <= 8'h39) begin
            r.valid    = 1'b1;
            r.code.len = 3'd5;
            r.code.pat = (digit <= 4'd5) ? (5'b11111 >> digit) : ~(5'b11111 >> (digit - 4'd5));
        end else begin
            r.valid = 1'b1;
            case (up)
                8'h20: r.code = {3'd0, 5'b00000};
                8'h41: r.code = {3'd2, 5'b00001};
                8'h42: r.code = {3'd4, 5'b01000};
                8'h43: r.code = {3'd4, 5'b01010};
                8'h44: r.code = {3'd3, 5'b00100};
                8'h45: r.code = {3'd1, 5'b00000};
                8'h46: r.code = {3'd4, 5'b00010};
                8'h47: r.code = {3'd3, 5'b00110};
                8'h48: r.code = {3'd4, 5'b00000};
                8'h49: r.code = {3'd2, 5'b00000};
                8'h4A: r.code = {3'd4, 5'b00111};
                8'h4B: r.code = {3'd3, 5'b00101};
                8'h4C: r.code = {3'd4, 5'b00100};
                8'h4D: r.code = {3'd2, 5'b00011};
                8'h4E: r.code = {3'd2, 5'b00010};
                8'h4F: r.code = {3'd3, 5'b00111};
                8'h50: r.code = {3'd4, 5'b00110};
                8'h51: r.code = {3'd4, 5'b01101};
                8'h52: r.code = {3'd3, 5'b00010};
                8'h53: r.code = {3'd3, 5'b00000};
                8'h54: r.code = {3'd1, 5'b00001};
                8'h55: r.code = {3'd3, 5'b00001};
                8'h56: r.code = {3'd4, 5'b00001};
                8'h57: r.code = {3'd3, 5'b00011};
                8'h58: r.code = {3'd4, 5'b01001};
                8'h59: r.code = {3'd4, 5'b01011};
                8'h5A: r.code = {3'd4, 5'b01100};
`ifdef MORSE_EOM_EN
                8'h04: begin
                    r.code = {3'd5, 5'b01010};
                    r.eom  = 1'b1;
                end
`endif
                default: r.valid = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler plus per-state unit counter; done_o flags the final clock of the final unit.
// Counter width grows by one bit when MORSE_EOM_EN is defined.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int CLKS_PER_UNIT = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [UNIT_W-1:0] lastUnit_i,
    output logic              done_o
);

    logic [CNT_W-1:0]  presc_q;
    logic [UNIT_W-1:0] unit_q;
    logic              unitEnd;

    assign unitEnd = (presc_q == CNT_W'(CLKS_PER_UNIT - 1));
    assign done_o  = unitEnd && (unit_q == lastUnit_i);

    // start_i is asserted on the clock that leaves a state, so the next state begins at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            unit_q  <= '0;
        end else if (start_i) begin
            presc_q <= '0;
            unit_q  <= '0;
        end else if (unitEnd) begin
            presc_q <= '0;
            unit_q  <= unit_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

endmodule

// File: rtl/morse_transmitter.sv
// ASCII-to-Morse serialiser with a one-character valid/ready handshake and registered outputs.
// Define MORSE_EOM_EN to send EOT (0x04) as the AR prosign followed by a 7-unit gap.
module morse_transmitter
    import morse_pkg::*;
#(
    parameter int CLKS_PER_UNIT = 1,
    parameter int CNT_W         = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_char,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_data_morse,
    output logic       o_busy,
    output logic       o_drop
);

    state_e            state_q, state_d;
    morse_code_t       code_q, code_d;
    logic [2:0]        elemIdx_q, elemIdx_d;
    logic              eom_q, eom_d;
    logic [UNIT_W-1:0] lastUnit;
    logic              timerStart;
    logic              timerDone;
    logic              data_q, ready_q, busy_q, drop_q;
    morse_lookup_t     lookup;

    assign lookup     = ascii_to_morse(i_char);
    assign timerStart = (state_q == IDLE) || (state_q == DROP) || timerDone;

    morse_unit_timer #(
        .CLKS_PER_UNIT(CLKS_PER_UNIT),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .start_i   (timerStart),
        .lastUnit_i(lastUnit),
        .done_o    (timerDone)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        elemIdx_d = elemIdx_q;
        eom_d     = eom_q;
        lastUnit  = '0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    code_d    = lookup.code;
                    eom_d     = lookup.eom;
                    elemIdx_d = lookup.code.len - 3'd1;
                    if (!lookup.valid)
                        state_d = DROP;
                    else if (lookup.code.len == 3'd0)
                        state_d = WORD_GAP;
                    else
                        state_d = MARK;
                end
            end
            MARK: begin
                lastUnit = code_q.pat[elemIdx_q] ? UNIT_W'(DASH_UNITS - 1) : UNIT_W'(DOT_UNITS - 1);
                if (timerDone) begin
                    if (elemIdx_q == 3'd0) begin
                        state_d = eom_q ? WORD_GAP : LETTER_GAP;
                    end else begin
                        elemIdx_d = elemIdx_q - 3'd1;
                        state_d   = ELEM_GAP;
                    end
                end
            end
            ELEM_GAP: begin
                lastUnit = UNIT_W'(ELEM_GAP_UNITS - 1);
                if (timerDone)
                    state_d = MARK;
            end
            LETTER_GAP: begin
                lastUnit = UNIT_W'(LETTER_GAP_UNITS - 1);
                if (timerDone)
                    state_d = IDLE;
            end
            WORD_GAP: begin
`ifdef MORSE_EOM_EN
                lastUnit = eom_q ? UNIT_W'(EOM_WORD_UNITS - 1) : UNIT_W'(WORD_EXTRA_UNITS - 1);
`else
                lastUnit = UNIT_W'(WORD_EXTRA_UNITS - 1);
`endif
                if (timerDone)
                    state_d = IDLE;
            end
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q as real flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            elemIdx_q <= '0;
            eom_q     <= 1'b0;
            data_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            elemIdx_q <= elemIdx_d;
            eom_q     <= eom_d;
            data_q    <= (state_d == MARK);
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
            drop_q    <= (state_d == DROP);
        end
    end

    assign o_data_morse = data_q;
    assign o_ready      = ready_q;
    assign o_busy       = busy_q;
    assign o_drop       = drop_q;

endmodule

// File: tb/tb_morse_transmitter.sv
// Scoreboard bench: one DUT at 1 clock/unit, one at 3 clocks/unit; expected
// {data,busy,ready,drop} per cycle is queued from a dot/dash string model.
module tb_morse_transmitter;

    logic       clock;
    logic       reset;
    logic [7:0] char1, char3;
    logic       valid1, valid3;
    logic       ready1, data1, busy1, drop1;
    logic       ready3, data3, busy3, drop3;

    logic [3:0] expQ[$];
    int         testsRun;
    int         testsFailed;

    morse_transmitter #(.CLKS_PER_UNIT(1), .CNT_W(16)) dut1 (
        .i_clk(clock), .i_rst(reset), .i_char(char1), .i_valid(valid1),
        .o_ready(ready1), .o_data_morse(data1), .o_busy(busy1), .o_drop(drop1)
    );

    morse_transmitter #(.CLKS_PER_UNIT(3), .CNT_W(16)) dut3 (
        .i_clk(clock), .i_rst(reset), .i_char(char3), .i_valid(valid3),
        .o_ready(ready3), .o_data_morse(data3), .o_busy(busy3), .o_drop(drop3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [3:0] obs(input bit slow);
        return slow ? {data3, busy3, ready3, drop3} : {data1, busy1, ready1, drop1};
    endfunction

    function automatic string morseOf(input logic [7:0] c);
        case (c)
            8'h41, 8'h61: return ".-";
            8'h54, 8'h74: return "-";
            8'h45, 8'h65: return ".";
            8'h4B, 8'h6B: return "-.-";
            8'h51, 8'h71: return "--.-";
            8'h5A, 8'h7A: return "--..";
            8'h30:        return "-----";
            8'h35:        return ".....";
            8'h39:        return "----.";
`ifdef MORSE_EOM_EN
            8'h04:        return ".-.-.";
`endif
            default:      return "";
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic pushLevel(input bit d, input int units, input int cpu);
        repeat (units * cpu) expQ.push_back({d, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic pushChar(input logic [7:0] c, input int cpu);
        string m;
        m = morseOf(c);
        if (c == 8'h20) begin
            pushLevel(1'b0, 4, cpu);
        end else if (m.len() == 0) begin
            expQ.push_back(4'b0101);
        end else begin
            for (int i = 0; i < m.len(); i++) begin
                pushLevel(1'b1, (m[i] == 8'h2D) ? 3 : 1, cpu);
                if (i < m.len() - 1)
                    pushLevel(1'b0, 1, cpu);
            end
            pushLevel(1'b0, (c == 8'h04) ? 7 : 3, cpu);
        end
        expQ.push_back(4'b0010);
    endtask

    task automatic drain(input string name);
        logic [3:0] e;
        int step;
        step = 0;
        while (expQ.size() > 0) begin
            @(negedge clock);
            e = expQ.pop_front();
            checkOutput($sformatf("%s[%0d]", name, step), {28'd0, obs(name[0] == "S")}, {28'd0, e});
            step++;
        end
    endtask

    task automatic driveChar(input logic [7:0] c, input bit slow);
        int waited;
        waited = 0;
        while (obs(slow)[1] !== 1'b1 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (slow) begin char3 = c; valid3 = 1'b1; end
        else      begin char1 = c; valid1 = 1'b1; end
        if (waited >= 100)
            checkOutput("readyTimeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        valid1 = 1'b0; valid3 = 1'b0;
        char1  = 8'h3F; char3 = 8'h3F;
    endtask

    task automatic applyStimulus(input logic [7:0] c, input bit slow);
        pushChar(c, slow ? 3 : 1);
        driveChar(c, slow);
        drain($sformatf("%s0x%02h", slow ? "S" : "F", c));
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset  = 1'b1;
        valid1 = 1'b0; valid3 = 1'b0;
        char1  = 8'h00; char3 = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("resetFast", {28'd0, obs(1'b0)}, 32'h2);
        checkOutput("resetSlow", {28'd0, obs(1'b1)}, 32'h2);

        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h54, 1'b1);
        applyStimulus(8'h6B, 1'b1);
        applyStimulus(8'h65, 1'b0);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h45, 1'b0);
        applyStimulus(8'h23, 1'b0);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h4B, 1'b0);
        applyStimulus(8'h30, 1'b0);
        applyStimulus(8'h39, 1'b0);
        applyStimulus(8'h71, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h7F, 1'b0);

        // '5' interrupted by reset during its third dot
        pushLevel(1'b1, 1, 1); pushLevel(1'b0, 1, 1);
        pushLevel(1'b1, 1, 1); pushLevel(1'b0, 1, 1);
        pushLevel(1'b1, 1, 1);
        driveChar(8'h35, 1'b0);
        drain("F5");
        #1 reset = 1'b1;
        #1 checkOutput("rstImmediate", {28'd0, obs(1'b0)}, 32'h2);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkOutput($sformatf("rstQuiet[%0d]", i), {28'd0, obs(1'b0)}, 32'h2);
        end

        applyStimulus(8'h45, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
